// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC and addresses a combinational ROM.
// It registers the returned word into an IF/ID slot, which decode consumes
// through a valid/ready handshake. A redirect retargets the PC and flushes
// the slot. A bad PC (misaligned or past the ROM) emits one fault entry and
// parks the stage in HALT until the next redirect.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES  = 1024,
    parameter logic [31:0] FAULT_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_fault,
    output logic        halted,
    output logic [31:0] fetch_count
);

    localparam logic [0:0]  ST_RUN  = 1'b0;
    localparam logic [0:0]  ST_HALT = 1'b1;
    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

    logic [31:0] r_pc;
    logic [0:0]  r_state;
    logic        r_out_valid;
    logic [31:0] r_out_instr;
    logic [31:0] r_out_pc;
    logic        r_out_fault;
    logic [31:0] r_fetch_count;

    logic        w_done;
    logic        w_slot_free;
    logic        w_bad_pc;

    assign w_done      = r_out_valid & out_ready;
    assign w_slot_free = !r_out_valid | out_ready;
    assign w_bad_pc    = (r_pc[1:0] != 2'b00) || (r_pc > LAST_PC);

    assign imem_addr   = r_pc;
    assign out_valid   = r_out_valid;
    assign out_instr   = r_out_instr;
    assign out_pc      = r_out_pc;
    assign out_fault   = r_out_fault;
    assign halted      = (r_state == ST_HALT);
    assign fetch_count = r_fetch_count;

    // Count every completed handshake, including one that coincides with a redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_count <= 32'd0;
        end else if (w_done) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    // PC, state and IF/ID slot update; the branches are ordered by priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_state     <= ST_RUN;
            r_out_valid <= 1'b0;
            r_out_instr <= 32'd0;
            r_out_pc    <= 32'd0;
            r_out_fault <= 1'b0;
        end else if (redirect_valid) begin
            // The ROM word for the old PC is dropped along with any pending entry.
            r_pc        <= redirect_pc;
            r_state     <= ST_RUN;
            r_out_valid <= 1'b0;
            r_out_fault <= 1'b0;
        end else if (r_state == ST_HALT) begin
            // Only the fault entry remains; let it drain, then sit idle.
            r_out_valid <= r_out_valid & !out_ready;
        end else if (!enable || !w_slot_free) begin
            // Stalled: the entry held in the slot must not be overwritten.
            if (!enable && w_done) begin
                r_out_valid <= 1'b0;
            end
        end else if (w_bad_pc) begin
            r_out_valid <= 1'b1;
            r_out_fault <= 1'b1;
            r_out_instr <= FAULT_INSTR;
            r_out_pc    <= r_pc;
            r_state     <= ST_HALT;
        end else begin
            r_out_valid <= 1'b1;
            r_out_fault <= 1'b0;
            r_out_instr <= imem_rdata;
            r_out_pc    <= r_pc;
            r_pc        <= r_pc + 32'd4;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios followed by randomized traffic.
// Every cycle is compared against a behavioural model of the fetch rules.
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam int unsigned IMEM_BYTES  = 1024;
    localparam logic [31:0] FAULT_INSTR = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_fault;
    logic        halted;
    logic [31:0] fetch_count;

    int nchk = 0;
    int nerr = 0;

    logic [31:0] rom [256];

    // Reference state
    logic [31:0] m_pc;
    logic        m_halt;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_opc;
    logic        m_fault;
    logic [31:0] m_cnt;

    if_fetch_stage #(
        .RESET_PC(RESET_PC),
        .IMEM_BYTES(IMEM_BYTES),
        .FAULT_INSTR(FAULT_INSTR)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .out_fault(out_fault),
        .halted(halted),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    assign imem_rdata = (imem_addr < 32'(IMEM_BYTES)) ? rom[imem_addr[9:2]] : 32'hBAD0_BAD0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit pc_is_bad(input logic [31:0] pc);
        return (pc % 4 != 0) || (pc > 32'(IMEM_BYTES - 4));
    endfunction

    task automatic model_reset();
        m_pc = RESET_PC; m_halt = 0; m_valid = 0;
        m_instr = 0; m_opc = 0; m_fault = 0; m_cnt = 0;
    endtask

    // One clock of the fetch rules, evaluated from the pre-edge state.
    task automatic model_step(input logic en, input logic rdy, input logic rv, input logic [31:0] rpc);
        bit done;
        done = m_valid && rdy;
        if (done) m_cnt = m_cnt + 1;
        if (rv) begin
            m_pc = rpc; m_halt = 0; m_valid = 0; m_fault = 0;
        end else if (m_halt) begin
            m_valid = m_valid && !rdy;
        end else if (!en || (m_valid && !rdy)) begin
            if (!en && done) m_valid = 0;
        end else if (pc_is_bad(m_pc)) begin
            m_valid = 1; m_fault = 1; m_instr = FAULT_INSTR; m_opc = m_pc; m_halt = 1;
        end else begin
            m_valid = 1; m_fault = 0; m_instr = rom[m_pc[9:2]]; m_opc = m_pc;
            m_pc = m_pc + 4;
        end
    endtask

    task automatic compare_all();
        check_eq("out_valid", 32'(out_valid), 32'(m_valid));
        check_eq("out_fault", 32'(out_fault), 32'(m_fault));
        check_eq("out_pc", out_pc, m_opc);
        check_eq("out_instr", out_instr, m_instr);
        check_eq("halted", 32'(halted), 32'(m_halt));
        check_eq("fetch_count", fetch_count, m_cnt);
        check_eq("imem_addr", imem_addr, m_pc);
    endtask

    // Drive one cycle of inputs, clock it, then compare against the model.
    task automatic cyc(input logic en, input logic rdy, input logic rv, input logic [31:0] rpc);
        enable = en; out_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
        #1;
        check_eq("imem_addr_pre", imem_addr, m_pc);
        @(posedge clk);
        model_step(en, rdy, rv, rpc);
        #1;
        compare_all();
    endtask

    initial begin
        clk = 0; rst_n = 0;
        enable = 1; out_ready = 1; redirect_valid = 0; redirect_pc = 0;
        for (int i = 0; i < 256; i++) rom[i] = $urandom;
        rom[0] = 32'h1111_1111; rom[1] = 32'h2222_2222; rom[2] = 32'h3333_3333;
        model_reset();
        #3;
        compare_all();
        #9 rst_n = 1;

        // Sequential fetch after reset, then backpressure on the entry at pc 4
        cyc(1, 1, 0, 0);
        check_eq("first_pc", out_pc, 32'h0);
        check_eq("first_instr", out_instr, 32'h1111_1111);
        cyc(1, 1, 0, 0);
        check_eq("second_instr", out_instr, 32'h2222_2222);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
        check_eq("bp_pc_hold", out_pc, 32'h4);
        check_eq("bp_addr_hold", imem_addr, 32'h8);
        check_eq("bp_count_hold", fetch_count, 32'd1);
        cyc(1, 1, 0, 0);
        check_eq("after_bp_pc", out_pc, 32'h8);
        check_eq("after_bp_instr", out_instr, 32'h3333_3333);
        cyc(1, 1, 0, 0);
        check_eq("three_handshakes", fetch_count, 32'd3);

        // Redirect flushing a pending entry
        cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 32'h40);
        check_eq("flush_valid", 32'(out_valid), 32'd0);
        check_eq("flush_count", fetch_count, 32'd3);
        cyc(1, 1, 0, 0);
        check_eq("redir_pc", out_pc, 32'h40);

        // Misaligned fault, drain in HALT, recovery by redirect
        cyc(1, 1, 1, 32'h42);
        cyc(1, 0, 0, 0);
        check_eq("mis_fault", 32'(out_fault), 32'd1);
        check_eq("mis_pc", out_pc, 32'h42);
        check_eq("mis_instr", out_instr, FAULT_INSTR);
        check_eq("mis_halted", 32'(halted), 32'd1);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        check_eq("halt_drained", 32'(out_valid), 32'd0);
        check_eq("halt_pc", imem_addr, 32'h42);
        cyc(0, 1, 1, 32'h10);
        check_eq("unhalt", 32'(halted), 32'd0);
        cyc(1, 1, 0, 0);
        check_eq("recover_pc", out_pc, 32'h10);

        // Range boundary: 1020 fetches, 1024 faults
        cyc(1, 1, 1, 32'd1016);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        check_eq("last_ok_pc", out_pc, 32'd1020);
        check_eq("last_ok_fault", 32'(out_fault), 32'd0);
        check_eq("last_ok_instr", out_instr, rom[255]);
        cyc(1, 1, 0, 0);
        check_eq("range_fault", 32'(out_fault), 32'd1);
        check_eq("range_pc", out_pc, 32'd1024);
        check_eq("range_halt", 32'(halted), 32'd1);

        // Asynchronous reset between edges with an entry pending
        cyc(1, 1, 1, 32'h0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check_eq("pre_areset_valid", 32'(out_valid), 32'd1);
        #3 rst_n = 0;
        #1;
        check_eq("areset_valid", 32'(out_valid), 32'd0);
        check_eq("areset_count", fetch_count, 32'd0);
        check_eq("areset_addr", imem_addr, RESET_PC);
        check_eq("areset_halted", 32'(halted), 32'd0);
        model_reset();
        #1 rst_n = 1;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic        en, rdy, rv;
            logic [31:0] rpc;
            en  = ($urandom % 8) != 0;
            rdy = ($urandom % 10) < 7;
            rv  = ($urandom % 16) == 0;
            case ($urandom % 5)
                0: rpc = 32'($urandom_range(0, 255)) * 4;
                1: rpc = 32'($urandom_range(0, 1023));
                2: rpc = 32'd1008 + 32'($urandom_range(0, 4)) * 4;
                3: rpc = $urandom;
                default: rpc = 32'($urandom_range(240, 255)) * 4;
            endcase
            cyc(en, rdy, rv, rpc);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
